// File: rtl/n64_pkg.sv
// Shared N64 single-wire protocol definitions: command codes, responder
// state encoding and line-coding time multipliers (in microseconds).
package n64_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam int BIT_US      = 4;
    localparam int SHORT_US    = 1;
    localparam int LONG_US     = 3;
    localparam int DSTOP_US    = 2;
    // Host low pulses shorter than this decode as 1, longer as 0.
    localparam int RX_SPLIT_US = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_LOW  = 3'd1,
        ST_RX_HIGH = 3'd2,
        ST_TURN    = 3'd3,
        ST_TX_LOW  = 3'd4,
        ST_TX_HIGH = 3'd5,
        ST_TX_STOP = 3'd6
    } resp_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the open-drain data line with edge detect.
// Flops reset high so an idle (pulled-up) line produces no spurious edge.
module n64_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;
    assign o_rise  = ~r_prev & r_sync;

endmodule

// File: rtl/n64_controller_responder.sv
// Device-side N64 controller endpoint: decodes host command bytes from the
// data line and replies with status or button data in N64 line coding.
module n64_controller_responder
    import n64_pkg::*;
#(
    parameter int          CLK_FREQ_HZ   = 50_000_000,
    parameter int          TURNAROUND_US = 2,
    parameter int          RX_TIMEOUT_US = 20,
    parameter logic [23:0] STATUS_ID     = 24'h050002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_in,
    output logic        line_oe,
    input  logic [31:0] buttons,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        busy,
    output logic        err,
    output logic [2:0]  dbg_state
);

    localparam int          US_CYC    = CLK_FREQ_HZ / 1_000_000;
    localparam logic [15:0] C_HALF    = 16'(US_CYC / 2);
    localparam logic [15:0] C_SPLIT   = 16'(RX_SPLIT_US * US_CYC);
    localparam logic [15:0] C_BIT     = 16'(BIT_US * US_CYC);
    localparam logic [15:0] C_SHORT   = 16'(SHORT_US * US_CYC);
    localparam logic [15:0] C_LONG    = 16'(LONG_US * US_CYC);
    localparam logic [15:0] C_DSTOP   = 16'(DSTOP_US * US_CYC);
    localparam logic [15:0] C_TURN    = 16'(TURNAROUND_US * US_CYC);
    localparam logic [15:0] C_TIMEOUT = 16'(RX_TIMEOUT_US * US_CYC);

    logic w_level;
    logic w_fall;
    logic w_rise;

    n64_line_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_line  (line_in),
        .o_level (w_level),
        .o_fall  (w_fall),
        .o_rise  (w_rise)
    );

    resp_state_e r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic [3:0]  r_rx_bits, w_rx_bits_nxt;
    logic [31:0] r_tx_shift, w_tx_shift_nxt;
    logic [5:0]  r_tx_bits, w_tx_bits_nxt;
    logic [7:0]  r_cmd_byte, w_cmd_byte_nxt;
    logic        r_cmd_valid, w_cmd_valid_nxt;
    logic        r_err, w_err_nxt;
    logic        r_busy;
    logic        r_line_oe;
    logic [15:0] w_low_dur;

    // Line-low portion of the current reply bit; the high portion fills the rest.
    assign w_low_dur = r_tx_shift[31] ? C_SHORT : C_LONG;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rx_shift_nxt  = r_rx_shift;
        w_rx_bits_nxt   = r_rx_bits;
        w_tx_shift_nxt  = r_tx_shift;
        w_tx_bits_nxt   = r_tx_bits;
        w_cmd_byte_nxt  = r_cmd_byte;
        w_cmd_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt    = ST_RX_LOW;
                    w_cnt_nxt      = 16'd1;
                    w_rx_bits_nxt  = 4'd0;
                    w_rx_shift_nxt = 8'h00;
                end
            end

            ST_RX_LOW: begin
                if (w_rise) begin
                    if (r_cnt < C_HALF || r_cnt > C_BIT) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 16'd0;
                    end else if (r_rx_bits == 4'd8) begin
                        w_cnt_nxt = 16'd0;
                        if (r_cnt < C_SPLIT) begin
                            w_cmd_valid_nxt = 1'b1;
                            w_cmd_byte_nxt  = r_rx_shift;
                            case (r_rx_shift)
                                CMD_POLL: begin
                                    w_tx_shift_nxt = buttons;
                                    w_tx_bits_nxt  = 6'd32;
                                    w_state_nxt    = ST_TURN;
                                end
                                CMD_STATUS, CMD_RESET: begin
                                    w_tx_shift_nxt = {STATUS_ID, 8'h00};
                                    w_tx_bits_nxt  = 6'd24;
                                    w_state_nxt    = ST_TURN;
                                end
                                default: w_state_nxt = ST_IDLE;
                            endcase
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_rx_shift_nxt = {r_rx_shift[6:0], (r_cnt < C_SPLIT)};
                        w_rx_bits_nxt  = r_rx_bits + 4'd1;
                        w_state_nxt    = ST_RX_HIGH;
                        w_cnt_nxt      = 16'd1;
                    end
                end else if (!w_level && r_cnt >= C_BIT) begin
                    // Low already longer than a full bit: abort without waiting for release.
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = sat_inc16(r_cnt);
                end
            end

            ST_RX_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = ST_RX_LOW;
                    w_cnt_nxt   = 16'd1;
                end else if (r_cnt >= C_TIMEOUT) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = sat_inc16(r_cnt);
                end
            end

            ST_TURN: begin
                if (r_cnt >= C_TURN - 16'd1) begin
                    w_state_nxt = ST_TX_LOW;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = sat_inc16(r_cnt);
                end
            end

            ST_TX_LOW: begin
                if (r_cnt >= w_low_dur - 16'd1) begin
                    w_state_nxt = ST_TX_HIGH;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = sat_inc16(r_cnt);
                end
            end

            ST_TX_HIGH: begin
                if (r_cnt >= C_BIT - w_low_dur - 16'd1) begin
                    w_cnt_nxt = 16'd0;
                    if (r_tx_bits == 6'd1) begin
                        w_tx_bits_nxt = 6'd0;
                        w_state_nxt   = ST_TX_STOP;
                    end else begin
                        w_tx_shift_nxt = {r_tx_shift[30:0], 1'b0};
                        w_tx_bits_nxt  = r_tx_bits - 6'd1;
                        w_state_nxt    = ST_TX_LOW;
                    end
                end else begin
                    w_cnt_nxt = sat_inc16(r_cnt);
                end
            end

            ST_TX_STOP: begin
                if (r_cnt >= C_DSTOP - 16'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = sat_inc16(r_cnt);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so line_oe and busy never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_rx_shift  <= 8'h00;
            r_rx_bits   <= 4'd0;
            r_tx_shift  <= 32'h0;
            r_tx_bits   <= 6'd0;
            r_cmd_byte  <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_line_oe   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_rx_bits   <= w_rx_bits_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_tx_bits   <= w_tx_bits_nxt;
            r_cmd_byte  <= w_cmd_byte_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_line_oe   <= (w_state_nxt == ST_TX_LOW) || (w_state_nxt == ST_TX_STOP);
        end
    end

    assign line_oe   = r_line_oe;
    assign cmd_valid = r_cmd_valid;
    assign cmd_byte  = r_cmd_byte;
    assign busy      = r_busy;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_n64_controller_responder.sv
// Directed bench for the N64 responder: host commands are bit-banged on
// line_in and the reply is decoded from line_oe pulse widths (US_CYC = 50).
module tb_n64_controller_responder;
    import n64_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_in = 1'b1;
    logic [31:0] buttons = 32'h0;
    logic        line_oe;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        busy;
    logic        err;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cv_cnt = 0;
    int err_cnt = 0;
    int oe_cnt = 0;

    n64_controller_responder dut (
        .clk       (clk),
        .rst       (rst),
        .line_in   (line_in),
        .line_oe   (line_oe),
        .buttons   (buttons),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) cv_cnt++;
        if (err) err_cnt++;
        if (line_oe) oe_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Host bit: 1 = 1us low / 3us high, 0 = 3us low / 1us high.
    task automatic send_bit(input logic b);
        line_in = 1'b0;
        tick(b ? 50 : 150);
        line_in = 1'b1;
        tick(b ? 150 : 50);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
        line_in = 1'b0;
        tick(50);
        line_in = 1'b1;
        tick(2);
        chk("cmd_valid_early", cmd_valid, 1'b0);
        tick(1);
        chk("cmd_valid", cmd_valid, 1'b1);
        chk("cmd_byte", cmd_byte, c);
    endtask

    // Called on the sample where cmd_valid is seen high.
    task automatic check_reply(input logic [31:0] exp, input int nbits, input string tag);
        int hi;
        int lo;
        int st;
        int exp_hi;
        tick(99);
        chk({tag, "_turn_quiet"}, line_oe, 1'b0);
        tick(1);
        chk({tag, "_turn_start"}, line_oe, 1'b1);
        chk({tag, "_busy_tx"}, busy, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            hi = 0;
            lo = 0;
            while (line_oe && hi < 400) begin hi++; tick(1); end
            while (!line_oe && lo < 400) begin lo++; tick(1); end
            exp_hi = exp[nbits - 1 - i] ? 50 : 150;
            chk($sformatf("%s_bit%0d_low", tag, i), hi, exp_hi);
            chk($sformatf("%s_bit%0d_high", tag, i), lo, 200 - exp_hi);
        end
        st = 0;
        while (line_oe && st < 400) begin st++; tick(1); end
        chk({tag, "_stop_len"}, st, 100);
        chk({tag, "_busy_release"}, busy, 1'b0);
        chk({tag, "_state_idle"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        int c0;
        int e0;
        int v0;

        // Reset values
        tick(3);
        chk("rst_line_oe", line_oe, 1'b0);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_cmd_byte", cmd_byte, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        tick(10);

        // Poll; buttons changed after accept must not affect the reply
        buttons = 32'h8000_0001;
        send_cmd(8'h01);
        buttons = 32'hFFFF_FFFF;
        check_reply(32'h8000_0001, 32, "poll");
        tick(20);

        // Status and reset commands share the same reply
        send_cmd(8'h00);
        check_reply(32'h0005_0002, 24, "status");
        tick(20);
        send_cmd(8'hFF);
        check_reply(32'h0005_0002, 24, "reset");
        tick(20);

        // Unknown command: accepted, silent, no error
        c0 = oe_cnt;
        e0 = err_cnt;
        send_cmd(8'h13);
        chk("unk_busy", busy, 1'b0);
        chk("unk_state", dbg_state, ST_IDLE);
        tick(300);
        chk("unk_no_oe", oe_cnt, c0);
        chk("unk_no_err", err_cnt, e0);

        // Bit 3 held low for 250 cycles
        v0 = cv_cnt;
        c0 = oe_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        line_in = 1'b0;
        tick(202);
        chk("long_low_err_early", err, 1'b0);
        chk("long_low_busy_early", busy, 1'b1);
        tick(1);
        chk("long_low_err", err, 1'b1);
        chk("long_low_busy", busy, 1'b0);
        chk("long_low_state", dbg_state, ST_IDLE);
        tick(1);
        chk("long_low_err_pulse", err, 1'b0);
        tick(46);
        line_in = 1'b1;
        tick(20);
        chk("long_low_no_cv", cv_cnt, v0);
        chk("long_low_no_oe", oe_cnt, c0);

        // High stall after bit 5
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        line_in = 1'b0;
        tick(150);
        line_in = 1'b1;
        tick(1002);
        chk("stall_err_early", err, 1'b0);
        tick(1);
        chk("stall_err", err, 1'b1);
        chk("stall_busy", busy, 1'b0);
        tick(50);
        buttons = 32'h1234_5678;
        send_cmd(8'h01);
        check_reply(32'h1234_5678, 32, "after_stall");
        tick(20);

        // Reset during reply bit 10
        buttons = 32'hA5A5_A5A5;
        send_cmd(8'h01);
        tick(100);
        chk("rst_tx_bit1", line_oe, 1'b1);
        tick(1810);
        chk("rst_tx_bit10", line_oe, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("rst_tx_oe", line_oe, 1'b0);
        chk("rst_tx_busy", busy, 1'b0);
        chk("rst_tx_cmd_byte", cmd_byte, 8'h00);
        rst = 1'b0;
        c0 = oe_cnt;
        tick(300);
        chk("rst_tx_dropped", oe_cnt, c0);
        send_cmd(8'h00);
        check_reply(32'h0005_0002, 24, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
